// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that broadcasts one finished result per cycle on the common data bus
module cdb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ROB_W = 4,
  parameter int DATA_W = 32,
  localparam int SRC_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      rollback,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ROB_W-1:0]  req_rob_index,
  input  logic [NUM_REQ*DATA_W-1:0] req_val,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [ROB_W-1:0]          cdb_rob_index,
  output logic [DATA_W-1:0]         cdb_val,
  output logic [SRC_W-1:0]          cdb_src,
  output logic                      err_zero_idx
);
  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d, grant_idx, j;
  logic              grant_found, accept;
  logic              cdb_valid_q, cdb_valid_d, err_q, err_d;
  logic [ROB_W-1:0]  rob_q, rob_d, grant_rob;
  logic [DATA_W-1:0] val_q, val_d, grant_val;
  logic [SRC_W-1:0]  src_q, src_d;
  // Scan from the farthest candidate down so the last hit is the first in round-robin order
  always_comb begin
    grant_found = 1'b0;
    grant_idx = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[j]) begin
        grant_found = 1'b1;
        grant_idx = j;
      end
    end
  end
  assign accept = grant_found & rdy_in & ~rollback;
  assign req_ready = accept ? NUM_REQ'(1) << grant_idx : '0;
  assign grant_rob = req_rob_index[int'(grant_idx)*ROB_W +: ROB_W];
  assign grant_val = req_val[int'(grant_idx)*DATA_W +: DATA_W];
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cdb_valid_d = cdb_valid_q;
    err_d = err_q;
    rob_d = rob_q;
    val_d = val_q;
    src_d = src_q;
    if (rdy_in) begin
      cdb_valid_d = accept && grant_rob != '0;
      rr_ptr_d = rollback ? '0 : !accept ? rr_ptr_q : grant_idx == SRC_W'(NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      err_d = err_q | (accept && grant_rob == '0);
      rob_d = cdb_valid_d ? grant_rob : rob_q;
      val_d = cdb_valid_d ? grant_val : val_q;
      src_d = cdb_valid_d ? grant_idx : src_q;
    end
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr_q <= '0;
      cdb_valid_q <= 1'b0;
      err_q <= 1'b0;
      rob_q <= '0;
      val_q <= '0;
      src_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      err_q <= err_d;
      rob_q <= rob_d;
      val_q <= val_d;
      src_q <= src_d;
    end
  end
  assign cdb_valid = cdb_valid_q;
  assign cdb_rob_index = rob_q;
  assign cdb_val = val_q;
  assign cdb_src = src_q;
  assign err_zero_idx = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table-driven check of the CDB arbiter plus hand-written reset and sticky-error sequences
module tb_cdb_arbiter;
  localparam logic [95:0] V  = {32'hC, 32'hB, 32'hA};
  localparam logic [95:0] VZ = {32'hC, 32'hB, 32'h55};
  typedef struct {
    logic        rdy;
    logic        rb;
    logic [2:0]  v;
    logic [11:0] idx;
    logic [95:0] val;
    logic [2:0]  e_rdy;
    logic        e_cv;
    logic [3:0]  e_idx;
    logic [31:0] e_val;
    logic [1:0]  e_src;
    logic        e_err;
  } vec_t;
  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, rb = 1'b0;
  logic [2:0]  req_valid = '0, req_ready;
  logic [11:0] req_rob_index = '0;
  logic [95:0] req_val = '0;
  logic        cdb_valid, err_zero_idx;
  logic [3:0]  cdb_rob_index;
  logic [31:0] cdb_val;
  logic [1:0]  cdb_src;
  int checks = 0, errors = 0;
  vec_t tv[$];
  cdb_arbiter #(.NUM_REQ(3), .ROB_W(4), .DATA_W(32)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rollback(rb),
    .req_valid(req_valid), .req_rob_index(req_rob_index), .req_val(req_val),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index),
    .cdb_val(cdb_val), .cdb_src(cdb_src), .err_zero_idx(err_zero_idx)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic check_cdb(input string tag, input logic cv, input logic [3:0] idx, input logic [31:0] val,
                           input logic [1:0] src, input logic err);
    check({tag, " cdb_valid"}, 64'(cdb_valid), 64'(cv));
    check({tag, " cdb_rob_index"}, 64'(cdb_rob_index), 64'(idx));
    check({tag, " cdb_val"}, 64'(cdb_val), 64'(val));
    check({tag, " cdb_src"}, 64'(cdb_src), 64'(src));
    check({tag, " err_zero_idx"}, 64'(err_zero_idx), 64'(err));
  endtask
  function automatic vec_t mk(logic r, logic b, logic [2:0] v, logic [11:0] i, logic [95:0] d, logic [2:0] er,
                              logic cv, logic [3:0] ei, logic [31:0] ev, logic [1:0] es, logic ee);
    vec_t t;
    t.rdy = r; t.rb = b; t.v = v; t.idx = i; t.val = d; t.e_rdy = er;
    t.e_cv = cv; t.e_idx = ei; t.e_val = ev; t.e_src = es; t.e_err = ee;
    return t;
  endfunction
  initial begin
    // all valid from rr_ptr 0: grants 0,1,2 then idle
    tv.push_back(mk(1, 0, 3'b111, 12'h765, V, 3'b001, 1, 5, 32'hA, 0, 0));
    tv.push_back(mk(1, 0, 3'b110, 12'h765, V, 3'b010, 1, 6, 32'hB, 1, 0));
    tv.push_back(mk(1, 0, 3'b100, 12'h765, V, 3'b100, 1, 7, 32'hC, 2, 0));
    tv.push_back(mk(1, 0, 3'b000, 12'h765, V, 3'b000, 0, 7, 32'hC, 2, 0));
    // unit1 stalled by rdy_in low, then accepted once
    tv.push_back(mk(0, 0, 3'b010, 12'h765, V, 3'b000, 0, 7, 32'hC, 2, 0));
    tv.push_back(mk(1, 0, 3'b010, 12'h765, V, 3'b010, 1, 6, 32'hB, 1, 0));
    tv.push_back(mk(1, 0, 3'b000, 12'h765, V, 3'b000, 0, 6, 32'hB, 1, 0));
    // freeze holds a live pulse
    tv.push_back(mk(1, 0, 3'b001, 12'h765, V, 3'b001, 1, 5, 32'hA, 0, 0));
    tv.push_back(mk(0, 0, 3'b000, 12'h765, V, 3'b000, 1, 5, 32'hA, 0, 0));
    tv.push_back(mk(1, 0, 3'b000, 12'h765, V, 3'b000, 0, 5, 32'hA, 0, 0));
    // units 0 and 2 alternate
    tv.push_back(mk(1, 0, 3'b100, 12'h765, V, 3'b100, 1, 7, 32'hC, 2, 0));
    tv.push_back(mk(1, 0, 3'b101, 12'h765, V, 3'b001, 1, 5, 32'hA, 0, 0));
    tv.push_back(mk(1, 0, 3'b101, 12'h765, V, 3'b100, 1, 7, 32'hC, 2, 0));
    tv.push_back(mk(1, 0, 3'b101, 12'h765, V, 3'b001, 1, 5, 32'hA, 0, 0));
    tv.push_back(mk(1, 0, 3'b101, 12'h765, V, 3'b100, 1, 7, 32'hC, 2, 0));
    // rollback overrides unit0 and resets rr_ptr
    tv.push_back(mk(1, 0, 3'b010, 12'h765, V, 3'b010, 1, 6, 32'hB, 1, 0));
    tv.push_back(mk(1, 1, 3'b001, 12'h763, V, 3'b000, 0, 6, 32'hB, 1, 0));
    tv.push_back(mk(1, 0, 3'b111, 12'h763, V, 3'b001, 1, 3, 32'hA, 0, 0));
    // rollback while frozen is ignored
    tv.push_back(mk(0, 1, 3'b000, 12'h765, V, 3'b000, 1, 3, 32'hA, 0, 0));
    tv.push_back(mk(1, 0, 3'b111, 12'h765, V, 3'b010, 1, 6, 32'hB, 1, 0));
    // zero index consumed without broadcast, sets sticky error
    tv.push_back(mk(1, 0, 3'b001, 12'h760, VZ, 3'b001, 0, 6, 32'hB, 1, 1));
    repeat (2) @(posedge clk);
    #1 check_cdb("reset", 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    foreach (tv[n]) begin
      @(negedge clk);
      rdy = tv[n].rdy; rb = tv[n].rb; req_valid = tv[n].v;
      req_rob_index = tv[n].idx; req_val = tv[n].val;
      #1 check($sformatf("v%0d req_ready", n), 64'(req_ready), 64'(tv[n].e_rdy));
      @(posedge clk);
      #1 check_cdb($sformatf("v%0d", n), tv[n].e_cv, tv[n].e_idx, tv[n].e_val, tv[n].e_src, tv[n].e_err);
    end
    @(negedge clk) {rdy, rb, req_valid} = {1'b1, 1'b0, 3'b000};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 check($sformatf("idle%0d err_zero_idx", c), 64'(err_zero_idx), 64'd1);
      check($sformatf("idle%0d cdb_valid", c), 64'(cdb_valid), 64'd0);
    end
    // asynchronous reset mid-broadcast
    @(negedge clk) begin req_valid = 3'b001; req_rob_index = 12'h765; req_val = V; end
    @(posedge clk);
    #1 check_cdb("pre-reset", 1, 5, 32'hA, 0, 1);
    req_valid = 3'b000;
    #2 rst = 1'b1;
    #1 check_cdb("async reset", 0, 0, 0, 0, 0);
    @(negedge clk) begin rst = 1'b0; req_valid = 3'b111; end
    #1 check("post-reset req_ready", 64'(req_ready), 64'b001);
    @(posedge clk);
    #1 check_cdb("post-reset", 1, 5, 32'hA, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
